// File: rtl/dct_row_round_buf.sv
// rtl/dct_row_round_buf.sv - DCT row round/shift/saturate stage with end-of-block tagging and a row FIFO
// Optional macro REC_TQ_SAT_CNT_EN adds the o_sat_cnt clip counter output.
module dct_row_round_buf #(
  parameter int LANES = 32,
  parameter int IN_W  = 28,
  parameter int OUT_W = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_valid,
  input  logic [LANES*IN_W-1:0]  i_data,
  input  logic [4:0]             i_shift,
  input  logic [1:0]             i_size,
  input  logic                   i_start,
  input  logic                   i_ready,
  input  logic                   i_ovf_clr,
  output logic                   o_valid,
  output logic [LANES*OUT_W-1:0] o_data,
  output logic                   o_last,
  output logic                   o_full,
  output logic                   o_ovf
`ifdef REC_TQ_SAT_CNT_EN
  ,
  output logic [15:0]            o_sat_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = IN_W + 1;

  // Saturation bounds expressed at the widened stage-1 width.
  localparam logic signed [TW-1:0] SAT_MAX = TW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [TW-1:0] SAT_MIN = ~SAT_MAX;

  // Stage-1 combinational rounding terms
  logic [6:0]             n_act;
  logic signed [TW-1:0]   rnd;
  logic signed [TW-1:0]   x_ext  [LANES];
  logic signed [TW-1:0]   sum    [LANES];
  logic signed [TW-1:0]   s1_next[LANES];

  // Stage-1 registers
  logic                   s1_valid;
  logic                   s1_last;
  logic signed [TW-1:0]   s1_t   [LANES];

  // Row framing
  logic [4:0]             row_cnt;
  logic [4:0]             row_idx;
  logic [4:0]             rows_m1;
  logic                   row_last;

  // Stage-2 saturated row
  logic [LANES*OUT_W-1:0] s2_row;
  logic [LANES-1:0]       s2_clip;

  // FIFO storage and control
  logic [LANES*OUT_W-1:0] mem_data[DEPTH];
  logic                   mem_last[DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [CW-1:0]          count;
  logic                   pop;
  logic                   wr_en;
  logic                   drop;

  // Sign-extend each lane, add the half-LSB rounding term and shift; inactive lanes forced to zero.
  always_comb begin
    n_act = 7'd4 << i_size;
    rnd   = '0;
    if (i_shift != 5'd0) begin
      rnd = TW'(1) << (i_shift - 5'd1);
    end
    for (int k = 0; k < LANES; k++) begin
      x_ext[k]   = {i_data[k*IN_W + IN_W - 1], i_data[k*IN_W +: IN_W]};
      sum[k]     = x_ext[k] + rnd;
      s1_next[k] = '0;
      if (7'(k) < n_act) begin
        s1_next[k] = sum[k] >>> i_shift;
      end
    end
  end

  // Current row position within the block; a start pulse makes this row row 0.
  always_comb begin
    case (i_size)
      2'b00:   rows_m1 = 5'd3;
      2'b01:   rows_m1 = 5'd7;
      2'b10:   rows_m1 = 5'd15;
      default: rows_m1 = 5'd31;
    endcase
    row_idx  = i_start ? 5'd0 : row_cnt;
    row_last = (row_idx == rows_m1);
  end

  // Row counter advances on every valid row, including rows later dropped at the FIFO.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_cnt <= '0;
    end else if (i_valid) begin
      row_cnt <= row_last ? 5'd0 : row_idx + 5'd1;
    end else if (i_start) begin
      row_cnt <= '0;
    end
  end

  // Stage-1 pipeline register: rounded/shifted lanes plus end-of-block tag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        s1_t[k] <= '0;
      end
    end else begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_last <= row_last;
        for (int k = 0; k < LANES; k++) begin
          s1_t[k] <= s1_next[k];
        end
      end
    end
  end

  // Stage 2: clamp each lane to the output range and note which lanes clipped.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      s2_clip[k] = 1'b0;
      if (s1_t[k] > SAT_MAX) begin
        s2_row[k*OUT_W +: OUT_W] = SAT_MAX[OUT_W-1:0];
        s2_clip[k]               = 1'b1;
      end else if (s1_t[k] < SAT_MIN) begin
        s2_row[k*OUT_W +: OUT_W] = SAT_MIN[OUT_W-1:0];
        s2_clip[k]               = 1'b1;
      end else begin
        s2_row[k*OUT_W +: OUT_W] = s1_t[k][OUT_W-1:0];
      end
    end
  end

  // FIFO handshake: a pop frees the slot the same-cycle write needs, so full+pop+write is legal.
  always_comb begin
    o_full  = (count == CW'(DEPTH));
    o_valid = (count != '0);
    pop     = o_valid & i_ready;
    wr_en   = s1_valid & (~o_full | pop);
    drop    = s1_valid & o_full & ~pop;
    o_data  = o_valid ? mem_data[rd_ptr] : '0;
    o_last  = o_valid ? mem_last[rd_ptr] : 1'b0;
  end

  // FIFO storage: payload only, validity is tracked by count so no reset is needed here.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[wr_ptr] <= s2_row;
      mem_last[wr_ptr] <= s1_last;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_ovf <= 1'b0;
    end else if (drop) begin
      o_ovf <= 1'b1;
    end else if (i_ovf_clr) begin
      o_ovf <= 1'b0;
    end
  end

`ifdef REC_TQ_SAT_CNT_EN
  logic [6:0]  clip_cnt;
  logic [16:0] sat_sum;

  // Number of clipped lanes on the row currently leaving stage 1.
  always_comb begin
    clip_cnt = '0;
    for (int k = 0; k < LANES; k++) begin
      clip_cnt = clip_cnt + 7'(s2_clip[k]);
    end
    sat_sum = 17'(o_sat_cnt) + 17'(clip_cnt);
  end

  // Saturating clip counter over rows actually stored; the start row's clips arrive after the clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_sat_cnt <= '0;
    end else if (i_start) begin
      o_sat_cnt <= '0;
    end else if (wr_en) begin
      o_sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_dct_row_round_buf.sv
// tb/tb_dct_row_round_buf.sv - self-checking bench for dct_row_round_buf against a queue-based reference model
module tb_dct_row_round_buf;

  localparam int LANES = 32;
  localparam int IN_W  = 28;
  localparam int OUT_W = 16;
  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic                   i_valid;
  logic [LANES*IN_W-1:0]  i_data;
  logic [4:0]             i_shift;
  logic [1:0]             i_size;
  logic                   i_start;
  logic                   i_ready;
  logic                   i_ovf_clr;
  logic                   o_valid;
  logic [LANES*OUT_W-1:0] o_data;
  logic                   o_last;
  logic                   o_full;
  logic                   o_ovf;
`ifdef REC_TQ_SAT_CNT_EN
  logic [15:0]            o_sat_cnt;
`endif

  always #5 clk = ~clk;

  dct_row_round_buf #(.LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .i_valid   (i_valid),
    .i_data    (i_data),
    .i_shift   (i_shift),
    .i_size    (i_size),
    .i_start   (i_start),
    .i_ready   (i_ready),
    .i_ovf_clr (i_ovf_clr),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_last    (o_last),
    .o_full    (o_full),
    .o_ovf     (o_ovf)
`ifdef REC_TQ_SAT_CNT_EN
    ,
    .o_sat_cnt (o_sat_cnt)
`endif
  );

  typedef struct {
    logic [LANES*OUT_W-1:0] d;
    logic                   last;
    int                     clips;
  } row_t;

  row_t q[$];
  row_t pipe;
  bit   pipe_v;
  int   mcnt;
  bit   movf;
  int   msat;
  int   n_vec;
  int   n_err;

  // Reference row: round-half-up division by 2^shift, then clamp, lanes beyond N are zero.
  function automatic row_t ref_row(input logic [LANES*IN_W-1:0] d, input int sz, input int sh, input bit last);
    row_t   r;
    longint x;
    longint t;
    longint div;
    int     n;
    logic signed [IN_W-1:0] lane;
    n       = 4 << sz;
    div     = longint'(1) << sh;
    r.d     = '0;
    r.last  = last;
    r.clips = 0;
    for (int k = 0; k < LANES; k++) begin
      if (k < n) begin
        lane = d[k*IN_W +: IN_W];
        x    = longint'(lane);
        t    = x + div / 2;
        if (t >= 0) t = t / div;
        else        t = -((-t + div - 1) / div);
        if (t > 32767) begin
          t = 32767;
          r.clips++;
        end else if (t < -32768) begin
          t = -32768;
          r.clips++;
        end
        r.d[k*OUT_W +: OUT_W] = t[15:0];
      end
    end
    return r;
  endfunction

  function automatic logic [LANES*IN_W-1:0] fill(input int val);
    logic [LANES*IN_W-1:0] v;
    for (int k = 0; k < LANES; k++) v[k*IN_W +: IN_W] = IN_W'(val);
    return v;
  endfunction

  function automatic logic [LANES*IN_W-1:0] rand_row();
    logic [LANES*IN_W-1:0] v;
    for (int k = 0; k < LANES; k++) begin
      case ($urandom % 4)
        0:       v[k*IN_W +: IN_W] = IN_W'($urandom);
        1:       v[k*IN_W +: IN_W] = IN_W'(int'($urandom_range(0, 2000)) - 1000);
        2:       v[k*IN_W +: IN_W] = ($urandom % 2 == 0) ? 28'h7FFFFFF : 28'h8000000;
        default: v[k*IN_W +: IN_W] = IN_W'(int'($urandom_range(0, 8000000)) - 4000000);
      endcase
    end
    return v;
  endfunction

  task automatic model_clear();
    q.delete();
    pipe_v = 1'b0;
    mcnt   = 0;
    movf   = 1'b0;
    msat   = 0;
  endtask

  // One clock edge of the reference: FIFO write/pop of the in-flight row, then capture of the new row.
  task automatic model_edge();
    int  pre;
    bit  popped;
    bit  wr;
    bit  dropped;
    int  idx;
    bit  last;
    if (!rstn) begin
      model_clear();
      return;
    end
    pre     = q.size();
    popped  = (pre > 0) && i_ready;
    wr      = 1'b0;
    dropped = 1'b0;
    if (popped) void'(q.pop_front());
    if (pipe_v) begin
      if (pre < DEPTH || popped) begin
        q.push_back(pipe);
        wr = 1'b1;
      end else begin
        dropped = 1'b1;
      end
    end
    if (dropped)        movf = 1'b1;
    else if (i_ovf_clr) movf = 1'b0;
    if (i_start)  msat = 0;
    else if (wr)  msat = (msat + pipe.clips > 65535) ? 65535 : msat + pipe.clips;
    if (i_valid) begin
      idx    = i_start ? 0 : mcnt;
      last   = (idx == (4 << int'(i_size)) - 1);
      mcnt   = last ? 0 : idx + 1;
      pipe   = ref_row(i_data, int'(i_size), int'(i_shift), last);
      pipe_v = 1'b1;
    end else begin
      pipe_v = 1'b0;
      if (i_start) mcnt = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    row_t e;
    e.d    = '0;
    e.last = 1'b0;
    if (q.size() > 0) e = q[0];
    chk("o_valid", 512'(o_valid), 512'(q.size() > 0));
    chk("o_data",  512'(o_data),  512'(e.d));
    chk("o_last",  512'(o_last),  512'(e.last));
    chk("o_full",  512'(o_full),  512'(q.size() == DEPTH));
    chk("o_ovf",   512'(o_ovf),   512'(movf));
`ifdef REC_TQ_SAT_CNT_EN
    chk("o_sat_cnt", 512'(o_sat_cnt), 512'(msat));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input bit v, input bit st, input bit rdy, input bit clr, input logic [LANES*IN_W-1:0] d);
    i_valid   = v;
    i_start   = st;
    i_ready   = rdy;
    i_ovf_clr = clr;
    i_data    = d;
    step();
  endtask

  logic [LANES*IN_W-1:0]  row;
  logic [LANES*OUT_W-1:0] exp_row;

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rstn      = 1'b0;
    i_valid   = 1'b0;
    i_start   = 1'b0;
    i_ready   = 1'b0;
    i_ovf_clr = 1'b0;
    i_data    = '0;
    i_shift   = 5'd0;
    i_size    = 2'b00;
    model_clear();

    // Reset state
    step();
    step();
    chk("rst_valid", 512'(o_valid), 512'(0));
    chk("rst_data",  512'(o_data),  512'(0));
    rstn = 1'b1;
    step();

    // Full-size row of 256 with shift 7: every lane rounds to 2, not last
    i_size  = 2'b11;
    i_shift = 5'd7;
    drive(1, 0, 1, 0, fill(256));
    chk("lat_not_yet", 512'(o_valid), 512'(0));
    drive(0, 0, 1, 0, '0);
    exp_row = {32{16'd2}};
    chk("tp1_valid", 512'(o_valid), 512'(1));
    chk("tp1_data",  512'(o_data),  512'(exp_row));
    chk("tp1_last",  512'(o_last),  512'(0));
    drive(0, 0, 1, 0, '0);

    // Shift 1 with negative, positive and saturating lanes
    i_shift = 5'd1;
    row = '0;
    row[0*IN_W +: IN_W] = 28'hFFFFFFD;
    row[1*IN_W +: IN_W] = 28'd3;
    row[2*IN_W +: IN_W] = 28'h7FFFFFF;
    drive(1, 0, 1, 0, row);
    drive(0, 0, 1, 0, '0);
    chk("tp2_lane0", 512'(o_data[15:0]),  512'(16'hFFFF));
    chk("tp2_lane1", 512'(o_data[31:16]), 512'(16'd2));
    chk("tp2_lane2", 512'(o_data[47:32]), 512'(16'h7FFF));
    drive(0, 0, 1, 0, '0);

    // Size 4 block framing: start + 4 rows, then a 5th row starts the next block
    i_size  = 2'b00;
    i_shift = 5'd0;
    drive(1, 1, 1, 0, fill(5));
    for (int r = 1; r < 5; r++) drive(1, 0, 1, 0, fill(5));
    drive(0, 0, 1, 0, '0);
    drive(0, 0, 1, 0, '0);

    // Overflow: 6 rows with no ready, then drain and clear
    i_size = 2'b01;
    drive(0, 1, 0, 0, '0);
    for (int r = 0; r < 6; r++) drive(1, 0, 0, 0, fill(100 + r));
    drive(0, 0, 0, 0, '0);
    chk("tp4_full", 512'(o_full), 512'(1));
    chk("tp4_ovf",  512'(o_ovf),  512'(1));
    for (int r = 0; r < 5; r++) drive(0, 0, 1, 0, '0);
    drive(0, 0, 1, 1, '0);
    chk("tp4_clr", 512'(o_ovf), 512'(0));

    // Full FIFO with simultaneous push/pop for 10 cycles: no drops
    drive(0, 1, 0, 0, '0);
    for (int r = 0; r < 4; r++) drive(1, 0, 0, 0, rand_row());
    drive(0, 0, 0, 0, '0);
    for (int r = 0; r < 10; r++) drive(1, 0, 1, 0, rand_row());
    chk("tp5_ovf", 512'(o_ovf), 512'(0));
    for (int r = 0; r < 6; r++) drive(0, 0, 1, 0, '0);

    // Asynchronous reset with rows buffered, then fresh block framing
    drive(0, 1, 0, 0, '0);
    for (int r = 0; r < 3; r++) drive(1, 0, 0, 0, rand_row());
    i_valid = 1'b0;
    #2;
    rstn = 1'b0;
    model_clear();
    #1;
    chk("async_rst_valid", 512'(o_valid), 512'(0));
    step();
    rstn = 1'b1;
    i_size  = 2'b01;
    i_shift = 5'd3;
    drive(1, 1, 1, 0, rand_row());
    for (int r = 1; r < 10; r++) drive(1, 0, 1, 0, rand_row());
    for (int r = 0; r < 3; r++) drive(0, 0, 1, 0, '0);

    // Randomized traffic; size/shift only change alongside a start pulse
    for (int c = 0; c < 400; c++) begin
      bit st;
      st = ($urandom % 20 == 0);
      if (st) begin
        i_size  = 2'($urandom % 4);
        i_shift = 5'($urandom_range(0, 20));
      end
      drive(($urandom % 10) < 7, st, ($urandom % 10) < 6, ($urandom % 20) == 0, rand_row());
    end
    for (int r = 0; r < 6; r++) drive(0, 0, 1, 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
